mantissa_mul_sequencer: RTL and testbench
=========================================

# mantissa_mul_sequencer

Iterative controller for the 24-bit significand multiply of the floating-point multiplier. It accepts a pair of mantissas over a valid/ready handshake and accumulates the exact 48-bit product over `DataSize/BitsPerCycle` cycles, `BitsPerCycle` multiplier bits per cycle. It then normalises the product and returns the upper 24 bits with guard and sticky bits. It sits between operand unpacking and the rounding/exponent-adjust stage of the MUL path.

## Interface
- `DataSize`, default 24: mantissa width, including the hidden bit.
- `BitsPerCycle`, default 4: multiplier bits consumed per accumulate cycle. Must divide `DataSize`. `N = DataSize/BitsPerCycle` (6 by default).
- `Clk`, in, 1: single clock, rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `InValid`, in, 1: an operand pair is presented.
- `InReady`, out, 1: the block can accept an operand pair.
- `Mantissa1`, in, `DataSize`: multiplicand.
- `Mantissa2`, in, `DataSize`: multiplier.
- `OutValid`, out, 1: the result fields are valid.
- `OutReady`, in, 1: downstream accepts the result.
- `Result`, out, `DataSize`: normalised upper product bits.
- `NormShift`, out, 1: product ≥ 2.0 (P[47] set); the exponent stage adds 1.
- `Guard`, out, 1: first bit below `Result`.
- `Sticky`, out, 1: OR of all bits below `Guard`.
- `Busy`, out, 1: state is not IDLE.

## Operation
- States:
  - IDLE
  - MUL
  - NORM
  - DONE
- IDLE:
  - `InReady` = 1 (forced to 0 while `Reset` is high).
  - On `InValid & InReady`, capture both mantissas, clear the 48-bit accumulator P, set the digit counter k = 0, and go to MUL.
- MUL:
  - Each cycle: P += (M1 × M2[k·B +: B]) << (k·B), where B = `BitsPerCycle`; then k += 1.
  - After the cycle with k = N−1, go to NORM.
  - P is 48 bits wide and never overflows. No truncation occurs before NORM.
- NORM (one cycle):
  - If P[47] = 1: `Result` = P[47:24], `Guard` = P[23], `Sticky` = |P[22:0], `NormShift` = 1.
  - Otherwise: `Result` = P[46:23], `Guard` = P[22], `Sticky` = |P[21:0], `NormShift` = 0.
  - All four outputs are registered at the end of NORM. Go to DONE.
- DONE:
  - `OutValid` = 1; result outputs are held stable.
  - On `OutValid & OutReady`, drop `OutValid` and go to IDLE.
- Zero operand: handled by the normal flow. P = 0 gives all outputs 0, `NormShift` 0.
- Operand inputs are ignored outside the IDLE accept cycle. Changes during MUL have no effect.
- `InReady` is 0 in MUL, NORM and DONE. No new operands are accepted in the same cycle as an output handshake.
- `Busy` = 1 in MUL, NORM and DONE.

## Timing
- Reset (asynchronous, immediate on assertion):
  - State goes to IDLE; P, k, `Result`, `Guard`, `Sticky` and `NormShift` go to 0.
  - `OutValid` = 0, `Busy` = 0, `InReady` = 0 while `Reset` is high.
  - `InReady` = 1 from the first cycle after `Reset` deasserts.
- Latency: accept edge at cycle 0, MUL in cycles 1..N, NORM in cycle N+1, `OutValid` high from cycle N+2 (cycle 8 by default).
- Back-to-back operations: output handshake at cycle t puts the block in IDLE at t+1, so the earliest next accept is at t+1. Minimum initiation interval is N+3 cycles.
- Backpressure: in DONE, `Result`, `Guard`, `Sticky` and `NormShift` do not change while `OutReady` = 0, for an unbounded number of cycles.
- Reset during MUL, NORM or DONE: the in-flight operation is discarded with no output handshake. The next operation after reset behaves exactly as from power-up.
- `InValid` asserted while `InReady` = 0: ignored. The upstream block holds its data.

## Test plan
- 1.0 × 1.0: `Mantissa1` = `Mantissa2` = 0x800000 → `Result` 0x800000, `NormShift` 0, `Guard` 0, `Sticky` 0. `OutValid` rises exactly 8 cycles after the accept edge.
- Maximum operands: 0xFFFFFF × 0xFFFFFF (P = 0xFFFFFE000001) → `Result` 0xFFFFFE, `NormShift` 1, `Guard` 0, `Sticky` 1.
- 1.5 × 1.5: 0xC00000 × 0xC00000 (P = 0x900000000000) → `Result` 0x900000, `NormShift` 1, `Guard` 0, `Sticky` 0.
- Zero operand with toggling inputs: 0x000000 × 0xABCDEF, with the mantissa inputs toggled randomly during MUL → all result outputs 0, `NormShift` 0.
- Backpressure: hold `OutReady` = 0 for 5 cycles in DONE → outputs stable, `InReady` 0 throughout. Assert `OutReady` → `OutValid` drops on the next cycle. A new pair presented with `InValid` = 1 is accepted exactly one cycle after the handshake.
- Reset mid-operation: assert `Reset` in the 3rd MUL cycle → `OutValid`, `Busy` and `Result` are 0 immediately and no result is emitted. After release, 0xC00000 × 0x800000 → `Result` 0xC00000, `NormShift` 0.

Source files
------------

// File: rtl/mantissa_mul_sequencer.sv
// Iterative radix-2^BitsPerCycle significand multiplier with normalisation.
// Produces the upper DataSize product bits plus guard and sticky.
module mantissa_mul_sequencer #(
    parameter int DataSize     = 24,
    parameter int BitsPerCycle = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                InValid,
    output logic                InReady,
    input  logic [DataSize-1:0] Mantissa1,
    input  logic [DataSize-1:0] Mantissa2,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [DataSize-1:0] Result,
    output logic                NormShift,
    output logic                Guard,
    output logic                Sticky,
    output logic                Busy
);

    localparam int N  = DataSize / BitsPerCycle;
    localparam int PW = 2 * DataSize;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        Idle,
        Mul,
        Norm,
        Done
    } stateT;

    stateT               state;
    logic [DataSize-1:0] m1;
    logic [DataSize-1:0] m2;
    logic [PW-1:0]       acc;
    logic [PW-1:0]       addend;
    logic [KW-1:0]       k;
    logic [BitsPerCycle-1:0] digit;
    int                  shamt;

    // One radix digit of the multiplier, weighted into the full-width product.
    always_comb begin
        shamt  = int'(k) * BitsPerCycle;
        digit  = BitsPerCycle'(m2 >> shamt);
        addend = (PW'(m1) * PW'(digit)) << shamt;
    end

    assign InReady = (state == Idle) && !Reset;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= Idle;
            m1        <= '0;
            m2        <= '0;
            acc       <= '0;
            k         <= '0;
            Result    <= '0;
            NormShift <= 1'b0;
            Guard     <= 1'b0;
            Sticky    <= 1'b0;
            OutValid  <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            unique case (state)
                Idle: begin
                    if (InValid) begin
                        m1    <= Mantissa1;
                        m2    <= Mantissa2;
                        acc   <= '0;
                        k     <= '0;
                        Busy  <= 1'b1;
                        state <= Mul;
                    end
                end
                Mul: begin
                    acc <= acc + addend;
                    k   <= k + KW'(1);
                    if (k == KW'(N - 1)) begin
                        state <= Norm;
                    end
                end
                Norm: begin
                    // Product in [2,4) needs a one-bit right shift to normalise.
                    if (acc[PW-1]) begin
                        Result    <= acc[PW-1 -: DataSize];
                        Guard     <= acc[DataSize-1];
                        Sticky    <= |acc[DataSize-2:0];
                        NormShift <= 1'b1;
                    end else begin
                        Result    <= acc[PW-2 -: DataSize];
                        Guard     <= acc[DataSize-2];
                        Sticky    <= |acc[DataSize-3:0];
                        NormShift <= 1'b0;
                    end
                    OutValid <= 1'b1;
                    state    <= Done;
                end
                Done: begin
                    if (OutReady) begin
                        OutValid <= 1'b0;
                        Busy     <= 1'b0;
                        state    <= Idle;
                    end
                end
                default: state <= Idle;
            endcase
        end
    end

endmodule

// File: tb/tb_mantissa_mul_sequencer.sv
// Scoreboard bench for mantissa_mul_sequencer: driver pushes expected
// results, a negedge monitor pops them on every output handshake.
module tb_mantissa_mul_sequencer;

    typedef struct packed {
        logic [23:0] res;
        logic        ns;
        logic        g;
        logic        s;
    } expT;

    logic        Clk;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [23:0] Mantissa1;
    logic [23:0] Mantissa2;
    logic        OutValid;
    logic        OutReady;
    logic [23:0] Result;
    logic        NormShift;
    logic        Guard;
    logic        Sticky;
    logic        Busy;

    expT sb[$];
    int  total  = 0;
    int  passed = 0;

    mantissa_mul_sequencer #(
        .DataSize    (24),
        .BitsPerCycle(4)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .Mantissa1(Mantissa1),
        .Mantissa2(Mantissa2),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Result   (Result),
        .NormShift(NormShift),
        .Guard    (Guard),
        .Sticky   (Sticky),
        .Busy     (Busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic expT mk(input logic [23:0] r, input logic n,
                               input logic g, input logic s);
        expT e;
        e.res = r;
        e.ns  = n;
        e.g   = g;
        e.s   = s;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every output handshake must match the oldest expectation.
    always @(negedge Clk) begin
        if (!Reset && OutValid && OutReady) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpectedOutput: got %0h expected none", Result);
            end else begin
                expT e;
                e = sb.pop_front();
                chk("result", {8'h0, Result}, {8'h0, e.res});
                chk("normShift", {31'h0, NormShift}, {31'h0, e.ns});
                chk("guard", {31'h0, Guard}, {31'h0, e.g});
                chk("sticky", {31'h0, Sticky}, {31'h0, e.s});
            end
        end
    end

    task automatic sendOp(input logic [23:0] a, input logic [23:0] b,
                          input expT e, input bit push);
        bit got;
        got = 1'b0;
        @(posedge Clk);
        #1;
        Mantissa1 = a;
        Mantissa2 = b;
        InValid   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (InReady) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            $display("FAIL acceptTimeout: got no InReady expected InReady");
            InValid = 1'b0;
        end else begin
            @(posedge Clk);
            #1;
            InValid = 1'b0;
            if (push) sb.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(negedge Clk);
        end
        chk("drained", sb.size(), 0);
    endtask

    initial begin
        int          lat;
        logic [23:0] holdRes;
        logic        holdNs;
        logic        holdG;
        logic        holdS;
        bit          seen;

        Reset     = 1'b1;
        InValid   = 1'b0;
        OutReady  = 1'b1;
        Mantissa1 = '0;
        Mantissa2 = '0;
        #2;
        chk("rstOutValid", {31'h0, OutValid}, 0);
        chk("rstBusy", {31'h0, Busy}, 0);
        chk("rstInReady", {31'h0, InReady}, 0);
        chk("rstResult", {8'h0, Result}, 0);
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("inReadyAfterRst", {31'h0, InReady}, 1);

        // 1.0 x 1.0 with latency measurement
        sendOp(24'h800000, 24'h800000, mk(24'h800000, 0, 0, 0), 1);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge Clk);
            if (OutValid) begin
                lat = c;
                break;
            end
        end
        chk("latency", lat, 8);
        drain();

        sendOp(24'hFFFFFF, 24'hFFFFFF, mk(24'hFFFFFE, 1, 0, 1), 1);
        sendOp(24'hC00000, 24'hC00000, mk(24'h900000, 1, 0, 0), 1);
        sendOp(24'h800001, 24'hC00000, mk(24'hC00001, 0, 1, 0), 1);

        // Zero operand with inputs churning during MUL
        sendOp(24'h000000, 24'hABCDEF, mk(24'h000000, 0, 0, 0), 1);
        repeat (6) begin
            @(posedge Clk);
            #1;
            Mantissa1 = 24'($urandom);
            Mantissa2 = 24'($urandom);
        end
        drain();

        // Backpressure in DONE, then back-to-back accept
        @(posedge Clk);
        #1;
        OutReady = 1'b0;
        sendOp(24'h800001, 24'h800001, mk(24'h800002, 0, 0, 1), 1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            if (OutValid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bpOutValid", {31'h0, seen}, 1);
        holdRes = Result;
        holdNs  = NormShift;
        holdG   = Guard;
        holdS   = Sticky;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk);
            #1;
            if (i == 0) begin
                Mantissa1 = 24'hC00000;
                Mantissa2 = 24'hC00000;
                InValid   = 1'b1;
            end
            @(negedge Clk);
            chk("bpResult", {8'h0, Result}, {8'h0, holdRes});
            chk("bpFlags", {29'h0, NormShift, Guard, Sticky},
                {29'h0, holdNs, holdG, holdS});
            chk("bpInReady", {31'h0, InReady}, 0);
            chk("bpValidHeld", {31'h0, OutValid}, 1);
        end
        @(posedge Clk);
        #1;
        OutReady = 1'b1;
        sb.push_back(mk(24'h900000, 1, 0, 0));
        @(negedge Clk);
        @(negedge Clk);
        chk("hsValidDrop", {31'h0, OutValid}, 0);
        chk("hsInReady", {31'h0, InReady}, 1);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
        @(negedge Clk);
        chk("b2bBusy", {31'h0, Busy}, 1);
        chk("b2bInReady", {31'h0, InReady}, 0);
        drain();

        // Reset in the third MUL cycle discards the operation
        sendOp(24'hFFFFFF, 24'hFFFFFF, mk(24'h0, 0, 0, 0), 0);
        @(negedge Clk);
        @(negedge Clk);
        @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        chk("midRstOutValid", {31'h0, OutValid}, 0);
        chk("midRstBusy", {31'h0, Busy}, 0);
        chk("midRstResult", {8'h0, Result}, 0);
        chk("midRstInReady", {31'h0, InReady}, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("postRstInReady", {31'h0, InReady}, 1);
        repeat (10) @(negedge Clk);
        chk("postRstNoOutput", {31'h0, OutValid}, 0);
        sendOp(24'hC00000, 24'h800000, mk(24'hC00000, 0, 0, 0), 1);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
